// File: rtl/lif_integrate_fire.sv
// 16-neuron integrate-and-fire stage: load decayed potentials, accumulate weight rows
// with per-neuron saturation, threshold, then hand potentials and spikes to the save path.

module lif_lane #(
  parameter int PW = 8,
  parameter int WW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          add,
  input  logic [PW-1:0] dec,
  input  logic [WW-1:0] w,
  input  logic [PW-1:0] thr,
  output logic [PW-1:0] acc,
  output logic          spk
);
  logic [PW:0]   sum;
  logic [PW-1:0] sat;

  // One guard bit is enough: the sign-extended weight is always narrower than the potential.
  assign sum = {acc[PW-1], acc} + {{(PW+1-WW){w[WW-1]}}, w};

  always_comb begin
    sat = sum[PW-1:0];
    if (sum[PW] != sum[PW-1])
      sat = sum[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (reset)     acc <= '0;
    else if (load) acc <= dec;
    else if (add)  acc <= sat;
  end

  assign spk = $signed(acc) >= $signed(thr);
endmodule

module lif_integrate_fire #(
  parameter int NUM_N = 16,
  parameter int PW    = 8,
  parameter int WW    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                skip_accum,
  input  logic [NUM_N*PW-1:0] decayed_potential_in,
  input  logic [PW-1:0]       threshold,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [NUM_N*WW-1:0] w_data,
  input  logic                w_last,
  output logic [NUM_N*PW-1:0] potential_out,
  output logic [NUM_N-1:0]    spk_out,
  output logic                out_valid,
  output logic                done,
  output logic                busy
);
  typedef enum logic [2:0] {IDLE, LOAD, ACCUM, FIRE, DONE} state_t;

  state_t                     state;
  logic                       skip_q;
  logic [NUM_N-1:0][PW-1:0]   dec, acc;
  logic [NUM_N-1:0][WW-1:0]   w;
  logic [NUM_N-1:0]           spk;
  logic                       ld, add;

  assign dec = decayed_potential_in;
  assign w   = w_data;
  assign ld  = (state == LOAD);
  assign add = (state == ACCUM) && w_valid;

  for (genvar i = 0; i < NUM_N; i++) begin : g_lane
    lif_lane #(.PW(PW), .WW(WW)) u_lane (
      .clk   (clk),
      .reset (reset),
      .load  (ld),
      .add   (add),
      .dec   (dec[i]),
      .w     (w[i]),
      .thr   (threshold),
      .acc   (acc[i]),
      .spk   (spk[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      skip_q        <= 1'b0;
      w_ready       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      out_valid     <= 1'b0;
      potential_out <= '0;
      spk_out       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= LOAD;
          skip_q    <= skip_accum;
          busy      <= 1'b1;
          out_valid <= 1'b0;
        end
        LOAD: begin
          if (skip_q) state <= FIRE;
          else begin
            state   <= ACCUM;
            w_ready <= 1'b1;
          end
        end
        ACCUM: if (w_valid && w_last) begin
          state   <= FIRE;
          w_ready <= 1'b0;
        end
        // Pre-reset potentials go out; the save path zeroes the neurons that fired.
        FIRE: begin
          potential_out <= acc;
          spk_out       <= spk;
          done          <= 1'b1;
          out_valid     <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lif_integrate_fire.sv
// Scoreboard bench for lif_integrate_fire: directed timesteps push expected results,
// a negedge monitor pops and compares whenever done pulses.

module tb_lif_integrate_fire;
  logic         clk = 1'b0;
  logic         reset, start, skip_accum, w_valid, w_last;
  logic [127:0] decayed_potential_in;
  logic [7:0]   threshold;
  logic [63:0]  w_data;
  logic         w_ready, out_valid, done, busy;
  logic [127:0] potential_out;
  logic [15:0]  spk_out;

  typedef struct {
    logic [127:0] pot;
    logic [15:0]  spk;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  bit   wr_seen = 1'b0;

  lif_integrate_fire dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .skip_accum           (skip_accum),
    .decayed_potential_in (decayed_potential_in),
    .threshold            (threshold),
    .w_valid              (w_valid),
    .w_ready              (w_ready),
    .w_data               (w_data),
    .w_last               (w_last),
    .potential_out        (potential_out),
    .spk_out              (spk_out),
    .out_valid            (out_valid),
    .done                 (done),
    .busy                 (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (w_ready) wr_seen = 1'b1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 128'(done), 128'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("potential_out", potential_out, e.pot);
        chk("spk_out", 128'(spk_out), 128'(e.spk));
        chk("out_valid_at_done", 128'(out_valid), 128'd1);
        chk("latency", 128'(cyc - start_cyc + 1), 128'(e.lat));
      end
    end
  end

  task automatic start_ts(input bit skip, input logic [127:0] pot, input logic [7:0] thr,
                          input bit push, input logic [127:0] epot, input logic [15:0] espk,
                          input int lat);
    int n = 0;
    while (busy && n < 64) begin @(negedge clk); n++; end
    if (busy) chk("idle_before_start", 128'(busy), 128'd0);
    if (push) exp_q.push_back('{pot: epot, spk: espk, lat: lat});
    start = 1'b1; skip_accum = skip; decayed_potential_in = pot; threshold = thr;
    @(posedge clk);
    #1 start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_row(input logic [63:0] d, input bit last);
    int n = 0;
    while (!w_ready && n < 64) begin @(negedge clk); n++; end
    if (!w_ready) chk("w_ready_timeout", 128'(w_ready), 128'd1);
    w_valid = 1'b1; w_data = d; w_last = last;
    @(negedge clk);
    w_valid = 1'b0; w_last = 1'b0; w_data = '0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 64) begin @(negedge clk); n++; end
    if (!done) chk("done_timeout", 128'(done), 128'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; skip_accum = 1'b0; w_valid = 1'b0; w_last = 1'b0;
    w_data = '0; decayed_potential_in = '0; threshold = '0;
    repeat (3) @(negedge clk);
    chk("rst_potential_out", potential_out, 128'd0);
    chk("rst_spk_out", 128'(spk_out), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_w_ready", 128'(w_ready), 128'd0);
    reset = 1'b0;
    @(negedge clk);

    // Abort mid-ACCUM after 2 of 4 rows; nothing is pushed, so any done is flagged.
    start_ts(1'b0, {16{8'h03}}, 8'd4, 1'b0, '0, '0, 0);
    send_row({16{4'h1}}, 1'b0);
    send_row({16{4'h1}}, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_w_ready", 128'(w_ready), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    chk("abort_potential_out", potential_out, 128'd0);
    chk("abort_spk_out", 128'(spk_out), 128'd0);
    reset = 1'b0;
    @(negedge clk);

    // Fresh timestep after the abort: lower 8 neurons +1 -> 4, upper stay 3.
    start_ts(1'b0, {16{8'h03}}, 8'd4, 1'b1, {{8{8'h03}}, {8{8'h04}}}, 16'h00FF, 4);
    send_row(64'h0000_0000_1111_1111, 1'b1);
    wait_done();

    // Skip path.
    wr_seen = 1'b0;
    start_ts(1'b1, {16{8'h05}}, 8'd5, 1'b1, {16{8'h05}}, 16'hFFFF, 3);
    wait_done();
    chk("skip_w_ready_never", 128'(wr_seen), 128'd0);

    // Single row, mixed signs: n0 +7, n1 -8.
    start_ts(1'b0, {16{8'h0A}}, 8'd12, 1'b1, {{14{8'h0A}}, 8'h02, 8'h11}, 16'h0001, 4);
    send_row(64'h0000_0000_0000_0087, 1'b1);
    wait_done();

    // Saturation: n0 120 +7 x3 -> 127, n1 -125 -8 x2 -> -128.
    start_ts(1'b0, {{14{8'h00}}, 8'h83, 8'h78}, 8'd127, 1'b1,
             {{14{8'h00}}, 8'h80, 8'h7F}, 16'h0001, 6);
    send_row(64'h0000_0000_0000_0087, 1'b0);
    send_row(64'h0000_0000_0000_0087, 1'b0);
    send_row(64'h0000_0000_0000_0007, 1'b1);
    wait_done();

    // Gaps of 2 cycles between rows, stray start in the first gap.
    // Lower: 20+3+0+1=24, upper: 20+3-2+1=22; threshold 23.
    start_ts(1'b0, {16{8'd20}}, 8'd23, 1'b1, {{8{8'h16}}, {8{8'h18}}}, 16'h00FF, 10);
    send_row({16{4'h3}}, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    send_row(64'hEEEE_EEEE_0000_0000, 1'b0);
    repeat (2) @(negedge clk);
    send_row({16{4'h1}}, 1'b1);
    wait_done();

    // Back-to-back: start in the IDLE cycle right after done, signed negative threshold.
    @(negedge clk);
    chk("b2b_out_valid_held", 128'(out_valid), 128'd1);
    start_ts(1'b1, {{13{8'h80}}, 8'h00, 8'hFE, 8'hFD}, 8'hFE, 1'b1,
             {{13{8'h80}}, 8'h00, 8'hFE, 8'hFD}, 16'h0006, 3);
    chk("b2b_out_valid_drop", 128'(out_valid), 128'd0);
    wait_done();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
